upower_stage_sequencer: RTL and testbench
=========================================

// Module: upower_stage_sequencer
// PURPOSE
//  Multi-cycle sequencer for the uPOWER datapath (register file, ALU64, data memory, write-back mux).
//  Accepts one instruction per valid/ack handshake and steps it through FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK.
//  Raises one stage enable per cycle, waits on a ready handshake from data memory, retires or halts.
//  Sits between the instruction source and the pipeline control unit's outputs.
// PARAMETERS
//  MEM_TIMEOUT  16     max MEMORY-state cycles waiting for mem_ready before ERROR (>=1)
//  CNT_W        16     width of retired_count
//  HALT_OPCODE  6'd0   primary opcode (Instruction[31:26]) that halts the sequencer
// PORTS
//  clk            in   1      clock, rising edge
//  rst            in   1      asynchronous reset, active-high
//  instr_valid    in   1      instruction source has an instruction on Instruction bus
//  opcode         in   6      Instruction[31:26] of latched IR
//  ctl_mem_read   in   1      MemRead from main control unit
//  ctl_mem_write  in   1      MemWrite from main control unit
//  ctl_reg_write  in   1      RegWrite from main control unit
//  mem_ready      in   1      data memory completes access this cycle
//  instr_ack      out  1      instruction accepted (source may advance)
//  ir_load        out  1      datapath latches Instruction into IR
//  id_en          out  1      decode / register-read enable
//  ex_en          out  1      ALU stage enable
//  mem_req        out  1      data memory request
//  mem_we         out  1      write qualifier for mem_req
//  wb_en          out  1      register-file write enable
//  retire         out  1      one-cycle pulse: instruction completed
//  halted         out  1      HALT state
//  error          out  1      ERROR state (memory timeout)
//  state          out  3      current state encoding
//  retired_count  out  CNT_W  retired instructions, saturating
// BEHAVIOUR
//  Reset (async, rst=1): state=IDLE; wait_cnt, retired_count, flags=0; all outputs 0. Reset mid-access aborts it, no retire.
//  All outputs Moore-decoded from registered state except retire, which is registered.
//  States: IDLE=0 FETCH=1 DECODE=2 EXECUTE=3 MEMORY=4 WRITEBACK=5 HALT=6 ERROR=7.
//  IDLE: instr_valid=1 -> FETCH; else stay.
//  FETCH (1 cycle): ir_load=1, instr_ack=1 -> DECODE.
//  DECODE (1 cycle): id_en=1. Capture rd/wr/rw flags from ctl_* and halt flag (opcode==HALT_OPCODE) at cycle end.
//   halt -> HALT; else -> EXECUTE.
//  EXECUTE (1 cycle): ex_en=1.
//   rd|wr -> MEMORY (wait_cnt cleared); else rw -> WRITEBACK; else retiring exit.
//  MEMORY: mem_req=1, mem_we=wr (wr has priority if rd and wr both set).
//   mem_ready=1 -> (rd&rw ? WRITEBACK : retiring exit).
//   mem_ready=0 and wait_cnt==MEM_TIMEOUT-1 -> ERROR; else wait_cnt+1.
//   mem_ready allowed in first MEMORY cycle (zero wait). Ready on the timeout cycle wins over ERROR.
//  WRITEBACK (1 cycle): wb_en=1 -> retiring exit.
//  Retiring exit: retire=1 next cycle; retired_count+1, saturating at 2^CNT_W-1.
//   Next state FETCH if instr_valid=1 this cycle (back-to-back), else IDLE.
//  HALT / ERROR: sticky until rst; all enables 0; instr_valid ignored, instr_ack stays 0.
//  Latency, valid sampled in IDLE at edge T:
//   ALU op: FETCH T+1, WB T+4, retire T+5.
//   Load: FETCH T+1, MEMORY T+4..T+4+w, WB T+5+w.
//   Throughput, ALU reg-write ops back-to-back: 4 cycles/instr.
//  Exactly one of ir_load/id_en/ex_en/mem_req/wb_en high in any cycle; none in IDLE/HALT/ERROR.
// TESTING
//  1 Reset mid-MEMORY (rst pulse) -> state=0, outputs 0, retired_count unchanged-to-0, no retire.
//  2 addi (opcode 14, rw=1), instr_valid held -> FETCH/DECODE/EXECUTE/WRITEBACK repeating;
//    retired_count=3 after 12 cycles from first FETCH.
//  3 ld (opcode 58, rd=1, rw=1), mem_ready after 3 wait cycles -> mem_req high 4 cycles, mem_we=0, wb_en one cycle, retire.
//  4 std (opcode 62, wr=1, rw=0), mem_ready in first MEMORY cycle -> mem_we=1 one cycle, no wb_en, retire next.
//  5 ld with mem_ready never asserted, MEM_TIMEOUT=16 -> mem_req high 16 cycles then state=7, error=1, instr_ack stays 0.
//    Variant: ready on 16th cycle -> WRITEBACK, no error.
//  6 opcode=HALT_OPCODE -> halted=1 after DECODE, no ex_en/retire.
//    CNT_W=2 with 5 retirements -> retired_count saturates at 3.

Source files
------------

// File: rtl/upower_stage_sequencer.sv
// Multi-cycle FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK sequencer for the uPOWER datapath.
// One instruction per valid/ack handshake; stage enables are Moore-decoded from the state register.
module upower_stage_sequencer #(
    parameter int unsigned MEM_TIMEOUT = 16,
    parameter int unsigned CNT_W       = 16,
    parameter logic [5:0]  HALT_OPCODE = 6'd0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             instr_valid,
    input  logic [5:0]       opcode,
    input  logic             ctl_mem_read,
    input  logic             ctl_mem_write,
    input  logic             ctl_reg_write,
    input  logic             mem_ready,
    output logic             instr_ack,
    output logic             ir_load,
    output logic             id_en,
    output logic             ex_en,
    output logic             mem_req,
    output logic             mem_we,
    output logic             wb_en,
    output logic             retire,
    output logic             halted,
    output logic             error,
    output logic [2:0]       state,
    output logic [CNT_W-1:0] retired_count
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_FETCH     = 3'd1,
        S_DECODE    = 3'd2,
        S_EXECUTE   = 3'd3,
        S_MEMORY    = 3'd4,
        S_WRITEBACK = 3'd5,
        S_HALT      = 3'd6,
        S_ERROR     = 3'd7
    } state_t;

    localparam int unsigned       WAIT_W    = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

    state_t             r_state;
    state_t             w_next;
    logic               w_retire_exit;
    logic [WAIT_W-1:0]  r_wait_cnt;
    logic               r_rd;
    logic               r_wr;
    logic               r_rw;
    logic               r_retire;
    logic [CNT_W-1:0]   r_count;

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // NOTE: defaults come first so no path through the case leaves a signal unassigned (no latches).
    always_comb begin
        w_next        = r_state;
        w_retire_exit = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (instr_valid) w_next = S_FETCH;
            end
            S_FETCH: begin
                w_next = S_DECODE;
            end
            S_DECODE: begin
                w_next = (opcode == HALT_OPCODE) ? S_HALT : S_EXECUTE;
            end
            S_EXECUTE: begin
                if (r_rd || r_wr)  w_next = S_MEMORY;
                else if (r_rw)     w_next = S_WRITEBACK;
                else               w_retire_exit = 1'b1;
            end
            S_MEMORY: begin
                // A ready on the last permitted cycle still completes the access.
                if (mem_ready) begin
                    if (r_rd && r_rw) w_next = S_WRITEBACK;
                    else              w_retire_exit = 1'b1;
                end else if (r_wait_cnt == WAIT_LAST) begin
                    w_next = S_ERROR;
                end
            end
            S_WRITEBACK: begin
                w_retire_exit = 1'b1;
            end
            S_HALT, S_ERROR: begin
                w_next = r_state;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
        if (w_retire_exit) w_next = instr_valid ? S_FETCH : S_IDLE;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wait_cnt <= '0;
            r_rd       <= 1'b0;
            r_wr       <= 1'b0;
            r_rw       <= 1'b0;
            r_retire   <= 1'b0;
            r_count    <= '0;
        end else begin
            r_retire <= w_retire_exit;
            if (w_retire_exit && (r_count != {CNT_W{1'b1}})) begin
                r_count <= r_count + CNT_W'(1);
            end
            if (r_state == S_DECODE) begin
                r_rd <= ctl_mem_read;
                r_wr <= ctl_mem_write;
                r_rw <= ctl_reg_write;
            end
            if (r_state == S_EXECUTE) begin
                r_wait_cnt <= '0;
            end else if ((r_state == S_MEMORY) && !mem_ready) begin
                r_wait_cnt <= r_wait_cnt + WAIT_W'(1);
            end
        end
    end

    assign state         = r_state;
    assign instr_ack     = (r_state == S_FETCH);
    assign ir_load       = (r_state == S_FETCH);
    assign id_en         = (r_state == S_DECODE);
    assign ex_en         = (r_state == S_EXECUTE);
    assign mem_req       = (r_state == S_MEMORY);
    assign mem_we        = (r_state == S_MEMORY) && r_wr;
    assign wb_en         = (r_state == S_WRITEBACK);
    assign halted        = (r_state == S_HALT);
    assign error         = (r_state == S_ERROR);
    assign retire        = r_retire;
    assign retired_count = r_count;

endmodule

// File: tb/tb_upower_stage_sequencer.sv
// Bench for upower_stage_sequencer: programs of instructions are expanded into an expected per-cycle
// stage timeline from the sequencing rules, then replayed against a default DUT and a CNT_W=2 DUT.
module tb_upower_stage_sequencer;

    localparam int         TO       = 16;
    localparam logic [5:0] HALT_OPC = 6'd0;
    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_FETCH = 3'd1;
    localparam logic [2:0] ST_DEC   = 3'd2;
    localparam logic [2:0] ST_EXEC  = 3'd3;
    localparam logic [2:0] ST_MEM   = 3'd4;
    localparam logic [2:0] ST_WB    = 3'd5;
    localparam logic [2:0] ST_HALT  = 3'd6;
    localparam logic [2:0] ST_ERR   = 3'd7;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        instr_valid = 1'b0;
    logic [5:0]  opcode = 6'd0;
    logic        ctl_mem_read = 1'b0;
    logic        ctl_mem_write = 1'b0;
    logic        ctl_reg_write = 1'b0;
    logic        mem_ready = 1'b0;

    logic        instr_ack, ir_load, id_en, ex_en, mem_req, mem_we, wb_en, retire, halted, error;
    logic [2:0]  state;
    logic [15:0] retired_count;
    logic        s_instr_ack, s_ir_load, s_id_en, s_ex_en, s_mem_req, s_mem_we, s_wb_en;
    logic        s_retire, s_halted, s_error;
    logic [2:0]  s_state;
    logic [1:0]  s_retired_count;

    upower_stage_sequencer #(.MEM_TIMEOUT(TO), .CNT_W(16), .HALT_OPCODE(HALT_OPC)) u_dut (
        .clk(clk), .rst(rst), .instr_valid(instr_valid), .opcode(opcode),
        .ctl_mem_read(ctl_mem_read), .ctl_mem_write(ctl_mem_write), .ctl_reg_write(ctl_reg_write),
        .mem_ready(mem_ready), .instr_ack(instr_ack), .ir_load(ir_load), .id_en(id_en),
        .ex_en(ex_en), .mem_req(mem_req), .mem_we(mem_we), .wb_en(wb_en), .retire(retire),
        .halted(halted), .error(error), .state(state), .retired_count(retired_count)
    );

    upower_stage_sequencer #(.MEM_TIMEOUT(TO), .CNT_W(2), .HALT_OPCODE(HALT_OPC)) u_sat (
        .clk(clk), .rst(rst), .instr_valid(instr_valid), .opcode(opcode),
        .ctl_mem_read(ctl_mem_read), .ctl_mem_write(ctl_mem_write), .ctl_reg_write(ctl_reg_write),
        .mem_ready(mem_ready), .instr_ack(s_instr_ack), .ir_load(s_ir_load), .id_en(s_id_en),
        .ex_en(s_ex_en), .mem_req(s_mem_req), .mem_we(s_mem_we), .wb_en(s_wb_en), .retire(s_retire),
        .halted(s_halted), .error(s_error), .state(s_state), .retired_count(s_retired_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [5:0] opc;
        logic       rd;
        logic       wr;
        logic       rw;
        int         wait_c;   // idle MEMORY cycles before ready; >= TO means never ready
        int         gap;      // 0 = back-to-back, n = n IDLE cycles before FETCH
    } instr_t;

    typedef struct {
        logic [2:0] st;
        logic       valid;
        logic       ready;
        logic       ret;
        int         cnt;
        logic [5:0] opc;
        logic       rd;
        logic       wr;
        logic       rw;
    } cyc_t;

    instr_t      prog[$];
    cyc_t        tl[$];
    logic [27:0] obs_v[$];
    logic [15:0] obs_c[$];
    int          n_tests = 0;
    int          n_fail  = 0;
    logic        pend_ret;
    int          cnt;
    int          last_exit;

    function automatic logic rbit();
        return 1'($urandom_range(1, 0));
    endfunction

    function automatic instr_t mk(logic [5:0] opc, logic rd, logic wr, logic rw, int w, int gap);
        instr_t in;
        in.opc = opc; in.rd = rd; in.wr = wr; in.rw = rw; in.wait_c = w; in.gap = gap;
        return in;
    endfunction

    function automatic instr_t rnd_instr();
        instr_t in;
        in.opc    = ($urandom_range(0, 29) == 0) ? HALT_OPC : 6'($urandom_range(1, 63));
        in.rd     = rbit();
        in.wr     = rbit();
        in.rw     = rbit();
        in.wait_c = ($urandom_range(0, 9) == 0) ? int'($urandom_range(14, 20)) : int'($urandom_range(0, 4));
        in.gap    = int'($urandom_range(0, 2));
        return in;
    endfunction

    function automatic void push(logic [2:0] st, logic valid, logic ready, instr_t in);
        cyc_t c;
        c.st = st; c.valid = valid; c.ready = ready; c.ret = pend_ret; c.cnt = cnt;
        c.opc = in.opc; c.rd = in.rd; c.wr = in.wr; c.rw = in.rw;
        tl.push_back(c);
        pend_ret = 1'b0;
    endfunction

    // Expands prog into the expected cycle-by-cycle timeline, stopping at the first HALT or ERROR.
    function automatic void build();
        instr_t in;
        instr_t blank;
        cyc_t   c;
        int     n;
        int     g;
        tl.delete();
        pend_ret  = 1'b0;
        cnt       = 0;
        last_exit = -1;
        blank     = mk(6'd63, 1'b0, 1'b0, 1'b0, 0, 0);
        foreach (prog[k]) begin
            in = prog[k];
            if (last_exit >= 0 && in.gap == 0) begin
                c = tl[last_exit];
                c.valid = 1'b1;
                tl[last_exit] = c;
            end else begin
                g = (in.gap < 1) ? 1 : in.gap;
                for (int j = 0; j < g - 1; j++) push(ST_IDLE, 1'b0, rbit(), in);
                push(ST_IDLE, 1'b1, rbit(), in);
            end
            push(ST_FETCH, rbit(), rbit(), in);
            push(ST_DEC, rbit(), rbit(), in);
            if (in.opc == HALT_OPC) begin
                for (int j = 0; j < 5; j++) push(ST_HALT, rbit(), rbit(), in);
                return;
            end
            push(ST_EXEC, rbit(), rbit(), in);
            if (in.rd || in.wr) begin
                n = (in.wait_c < TO) ? in.wait_c + 1 : TO;
                for (int j = 0; j < n; j++) push(ST_MEM, rbit(), (j == in.wait_c), in);
                if (in.wait_c >= TO) begin
                    for (int j = 0; j < 5; j++) push(ST_ERR, rbit(), rbit(), in);
                    return;
                end
                if (in.rd && in.rw) push(ST_WB, rbit(), rbit(), in);
            end else if (in.rw) begin
                push(ST_WB, rbit(), rbit(), in);
            end
            last_exit = tl.size() - 1;
            c = tl[last_exit];
            c.valid = 1'b0;
            tl[last_exit] = c;
            pend_ret = 1'b1;
            cnt++;
        end
        for (int j = 0; j < 3; j++) push(ST_IDLE, 1'b0, rbit(), blank);
    endfunction

    // Expected {state, outputs} for both DUTs plus the saturated 2-bit count.
    function automatic logic [27:0] exp_vec(int i);
        cyc_t       c;
        logic [9:0] o;
        logic [1:0] s;
        c = tl[i];
        o = {c.st == ST_FETCH, c.st == ST_FETCH, c.st == ST_DEC, c.st == ST_EXEC, c.st == ST_MEM,
             (c.st == ST_MEM) && c.wr, c.st == ST_WB, c.ret, c.st == ST_HALT, c.st == ST_ERR};
        s = (c.cnt > 3) ? 2'd3 : 2'(c.cnt);
        return {c.st, o, c.st, o, s};
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        instr_valid = 1'b0; mem_ready = 1'b0; opcode = 6'd0;
        ctl_mem_read = 1'b0; ctl_mem_write = 1'b0; ctl_reg_write = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    // Replays the first `limit` timeline cycles, recording what both DUTs show in each.
    task automatic run(int limit);
        obs_v.delete();
        obs_c.delete();
        for (int i = 0; i < tl.size() && i < limit; i++) begin
            instr_valid   = tl[i].valid;
            mem_ready     = tl[i].ready;
            opcode        = tl[i].opc;
            ctl_mem_read  = tl[i].rd;
            ctl_mem_write = tl[i].wr;
            ctl_reg_write = tl[i].rw;
            obs_v.push_back({state, instr_ack, ir_load, id_en, ex_en, mem_req, mem_we, wb_en, retire,
                             halted, error, s_state, s_instr_ack, s_ir_load, s_id_en, s_ex_en, s_mem_req,
                             s_mem_we, s_wb_en, s_retire, s_halted, s_error, s_retired_count});
            obs_c.push_back(retired_count);
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        int m;
        do_reset();
        n_tests++;
        if ({state, instr_ack, ir_load, id_en, ex_en, mem_req, mem_we, wb_en, retire, halted, error} !== 13'd0) begin
            n_fail++;
            $display("FAIL reset_state got=%h exp=0", {state, instr_ack, ir_load, id_en, ex_en, mem_req,
                     mem_we, wb_en, retire, halted, error});
        end
        n_tests++;
        if ({retired_count, s_retired_count} !== 18'd0) begin
            n_fail++;
            $display("FAIL reset_count got=%0d/%0d exp=0/0", retired_count, s_retired_count);
        end
        prog = '{mk(6'd14, 1'b0, 1'b0, 1'b1, 0, 1), mk(6'd58, 1'b1, 1'b0, 1'b1, 10, 0)};
        build();
        m = 0;
        while (m < tl.size() && tl[m].st != ST_MEM) m++;
        run(m + 3);
        for (int i = 0; i < obs_v.size(); i++) begin
            n_tests++;
            if (obs_v[i] !== exp_vec(i)) begin
                n_fail++;
                $display("FAIL pre_reset cyc=%0d outs got=%h exp=%h", i, obs_v[i], exp_vec(i));
            end
            n_tests++;
            if (obs_c[i] !== 16'(tl[i].cnt)) begin
                n_fail++;
                $display("FAIL pre_reset cyc=%0d retired_count got=%0d exp=%0d", i, obs_c[i], tl[i].cnt);
            end
        end
        // Asynchronous reset in the middle of a MEMORY wait, away from any clock edge.
        #1 rst = 1'b1;
        #1;
        n_tests++;
        if ({state, s_state} !== 6'd0) begin
            n_fail++;
            $display("FAIL async_reset_state got=%0d/%0d exp=0/0", state, s_state);
        end
        n_tests++;
        if ({instr_ack, ir_load, id_en, ex_en, mem_req, mem_we, wb_en, retire, halted, error} !== 10'd0) begin
            n_fail++;
            $display("FAIL async_reset_outs got=%b exp=0", {instr_ack, ir_load, id_en, ex_en, mem_req,
                     mem_we, wb_en, retire, halted, error});
        end
        n_tests++;
        if ({retired_count, s_retired_count} !== 18'd0) begin
            n_fail++;
            $display("FAIL async_reset_count got=%0d/%0d exp=0/0", retired_count, s_retired_count);
        end
        @(negedge clk);
        instr_valid = 1'b0;
        mem_ready   = 1'b1;
        rst         = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_tests++;
            if ({state, retire, retired_count} !== 20'd0) begin
                n_fail++;
                $display("FAIL post_reset cyc=%0d state/retire/count got=%0d/%0d/%0d exp=0/0/0",
                         i, state, retire, retired_count);
            end
        end
    endtask

    task automatic test_alu_back_to_back();
        do_reset();
        prog = '{mk(6'd14, 1'b0, 1'b0, 1'b1, 0, 0), mk(6'd14, 1'b0, 1'b0, 1'b1, 0, 0),
                 mk(6'd14, 1'b0, 1'b0, 1'b1, 0, 0), mk(6'd31, 1'b0, 1'b0, 1'b0, 0, 2),
                 mk(6'd14, 1'b0, 1'b0, 1'b1, 0, 0)};
        build();
        run(tl.size());
        for (int i = 0; i < obs_v.size(); i++) begin
            n_tests++;
            if (obs_v[i] !== exp_vec(i)) begin
                n_fail++;
                $display("FAIL alu cyc=%0d outs got=%h exp=%h", i, obs_v[i], exp_vec(i));
            end
            n_tests++;
            if (obs_c[i] !== 16'(tl[i].cnt)) begin
                n_fail++;
                $display("FAIL alu cyc=%0d retired_count got=%0d exp=%0d", i, obs_c[i], tl[i].cnt);
            end
        end
        // Three back-to-back addi ops: first FETCH at cycle 1, so cycle 13 shows three retirements.
        n_tests++;
        if (obs_c[13] !== 16'd3) begin
            n_fail++;
            $display("FAIL alu_throughput retired_count got=%0d exp=3", obs_c[13]);
        end
    endtask

    task automatic test_load();
        do_reset();
        prog = '{mk(6'd58, 1'b1, 1'b0, 1'b1, 3, 1), mk(6'd58, 1'b1, 1'b0, 1'b1, 0, 0),
                 mk(6'd58, 1'b1, 1'b0, 1'b0, 2, 1)};
        build();
        run(tl.size());
        for (int i = 0; i < obs_v.size(); i++) begin
            n_tests++;
            if (obs_v[i] !== exp_vec(i)) begin
                n_fail++;
                $display("FAIL load cyc=%0d outs got=%h exp=%h", i, obs_v[i], exp_vec(i));
            end
            n_tests++;
            if (obs_c[i] !== 16'(tl[i].cnt)) begin
                n_fail++;
                $display("FAIL load cyc=%0d retired_count got=%0d exp=%0d", i, obs_c[i], tl[i].cnt);
            end
        end
    endtask

    task automatic test_store();
        do_reset();
        prog = '{mk(6'd62, 1'b0, 1'b1, 1'b0, 0, 1), mk(6'd62, 1'b1, 1'b1, 1'b1, 2, 0),
                 mk(6'd62, 1'b0, 1'b1, 1'b1, 1, 2)};
        build();
        run(tl.size());
        for (int i = 0; i < obs_v.size(); i++) begin
            n_tests++;
            if (obs_v[i] !== exp_vec(i)) begin
                n_fail++;
                $display("FAIL store cyc=%0d outs got=%h exp=%h", i, obs_v[i], exp_vec(i));
            end
            n_tests++;
            if (obs_c[i] !== 16'(tl[i].cnt)) begin
                n_fail++;
                $display("FAIL store cyc=%0d retired_count got=%0d exp=%0d", i, obs_c[i], tl[i].cnt);
            end
        end
    endtask

    task automatic test_timeout();
        do_reset();
        prog = '{mk(6'd58, 1'b1, 1'b0, 1'b1, TO - 1, 1), mk(6'd58, 1'b1, 1'b0, 1'b1, 1000, 0)};
        build();
        run(tl.size());
        for (int i = 0; i < obs_v.size(); i++) begin
            n_tests++;
            if (obs_v[i] !== exp_vec(i)) begin
                n_fail++;
                $display("FAIL timeout cyc=%0d outs got=%h exp=%h", i, obs_v[i], exp_vec(i));
            end
            n_tests++;
            if (obs_c[i] !== 16'(tl[i].cnt)) begin
                n_fail++;
                $display("FAIL timeout cyc=%0d retired_count got=%0d exp=%0d", i, obs_c[i], tl[i].cnt);
            end
        end
    endtask

    task automatic test_halt_saturation();
        do_reset();
        prog = '{mk(6'd14, 1'b0, 1'b0, 1'b1, 0, 1), mk(6'd14, 1'b0, 1'b0, 1'b1, 0, 0),
                 mk(6'd62, 1'b0, 1'b1, 1'b0, 0, 0), mk(6'd14, 1'b0, 1'b0, 1'b1, 0, 1),
                 mk(6'd31, 1'b0, 1'b0, 1'b0, 0, 0), mk(HALT_OPC, 1'b1, 1'b0, 1'b1, 0, 0)};
        build();
        run(tl.size());
        for (int i = 0; i < obs_v.size(); i++) begin
            n_tests++;
            if (obs_v[i] !== exp_vec(i)) begin
                n_fail++;
                $display("FAIL halt_sat cyc=%0d outs got=%h exp=%h", i, obs_v[i], exp_vec(i));
            end
            n_tests++;
            if (obs_c[i] !== 16'(tl[i].cnt)) begin
                n_fail++;
                $display("FAIL halt_sat cyc=%0d retired_count got=%0d exp=%0d", i, obs_c[i], tl[i].cnt);
            end
        end
    endtask

    task automatic test_random();
        for (int r = 0; r < 4; r++) begin
            do_reset();
            prog.delete();
            for (int k = 0; k < 25; k++) prog.push_back(rnd_instr());
            build();
            run(tl.size());
            for (int i = 0; i < obs_v.size(); i++) begin
                n_tests++;
                if (obs_v[i] !== exp_vec(i)) begin
                    n_fail++;
                    $display("FAIL random r=%0d cyc=%0d outs got=%h exp=%h", r, i, obs_v[i], exp_vec(i));
                end
                n_tests++;
                if (obs_c[i] !== 16'(tl[i].cnt)) begin
                    n_fail++;
                    $display("FAIL random r=%0d cyc=%0d retired_count got=%0d exp=%0d",
                             r, i, obs_c[i], tl[i].cnt);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_alu_back_to_back();
        test_load();
        test_store();
        test_timeout();
        test_halt_saturation();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
